// File: rtl/tetris_pkg.sv
// Shared types and default timing constants for the 8x8 LED Tetris game.
package tetris_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPAWN,
      CHECK,
      FALL,
      LOCK,
      OVER
   } drop_state_t;

   localparam int DEF_GRAV_DIV = 50;
   localparam int DEF_FAST_DIV = 5;

endpackage

// File: rtl/gravity_timer.sv
// Gravity step timer: counts clock cycles while running and emits a step
// whenever the count reaches the normal or fast period limit.
module gravity_timer
   import tetris_pkg::*;
#(
   parameter int GRAV_DIV = DEF_GRAV_DIV,
   parameter int FAST_DIV = DEF_FAST_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_run,
   input  logic i_fast,
   output logic o_step
);

   localparam int CW = $clog2(GRAV_DIV);
   localparam logic [CW-1:0] GRAV_LIM = CW'(GRAV_DIV - 1);
   localparam logic [CW-1:0] FAST_LIM = CW'(FAST_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_limit;

   // A count already past the fast limit steps immediately when fast is selected.
   assign w_limit = i_fast ? FAST_LIM : GRAV_LIM;
   assign o_step  = i_run && !i_clear && (r_cnt >= w_limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_run) begin
         r_cnt <= o_step ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/piece_drop_ctrl.sv
// Gravity and landing sequencer for the Tetris piece datapath.
// Define LOCK_DELAY_EN to give a landed piece one grace step before locking.
module piece_drop_ctrl
   import tetris_pkg::*;
#(
   parameter int GRAV_DIV = DEF_GRAV_DIV,
   parameter int FAST_DIV = DEF_FAST_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic game_en,
   input  logic down_fast,
   input  logic can_move_down,
   input  logic spawn_ok,
   output logic move_down,
   output logic lock_piece,
   output logic reset_piece,
   output logic game_over
);

   drop_state_t r_state;
   logic        r_move_down;
   logic        w_step;
   logic        w_timer_clear;
   logic        w_timer_run;
`ifdef LOCK_DELAY_EN
   logic        r_grace;
`endif

   assign w_timer_run   = (r_state == FALL);
   assign w_timer_clear = !game_en || (r_state != FALL);

   gravity_timer #(
      .GRAV_DIV(GRAV_DIV),
      .FAST_DIV(FAST_DIV)
   ) u_timer (
      .clk    (clk),
      .rst_n  (reset),
      .i_clear(w_timer_clear),
      .i_run  (w_timer_run),
      .i_fast (down_fast),
      .o_step (w_step)
   );

   // Dropping game_en always returns to IDLE ahead of any other event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_move_down <= 1'b0;
`ifdef LOCK_DELAY_EN
         r_grace     <= 1'b0;
`endif
      end else if (!game_en) begin
         r_state     <= IDLE;
         r_move_down <= 1'b0;
`ifdef LOCK_DELAY_EN
         r_grace     <= 1'b0;
`endif
      end else begin
         r_move_down <= 1'b0;
         case (r_state)
            IDLE: begin
`ifdef LOCK_DELAY_EN
               r_grace <= 1'b0;
`endif
               r_state <= SPAWN;
            end
            SPAWN: begin
`ifdef LOCK_DELAY_EN
               r_grace <= 1'b0;
`endif
               r_state <= CHECK;
            end
            CHECK: begin
               r_state <= spawn_ok ? FALL : OVER;
            end
            FALL: begin
               if (w_step) begin
                  if (can_move_down) begin
                     r_move_down <= 1'b1;
`ifdef LOCK_DELAY_EN
                     r_grace     <= 1'b0;
`endif
                  end else begin
`ifdef LOCK_DELAY_EN
                     if (!r_grace) begin
                        r_grace <= 1'b1;
                     end else begin
                        r_state <= LOCK;
                     end
`else
                     r_state <= LOCK;
`endif
                  end
               end
            end
            LOCK: begin
               r_state <= SPAWN;
            end
            OVER: begin
               r_state <= OVER;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign move_down   = r_move_down;
   assign lock_piece  = (r_state == LOCK);
   assign reset_piece = (r_state == SPAWN);
   assign game_over   = (r_state == OVER);

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Directed bench for piece_drop_ctrl with GRAV_DIV=8, FAST_DIV=2.
module tb_piece_drop_ctrl;

   typedef struct {
      int         n;
      logic       en;
      logic       sok;
      logic       cmd;
      logic       fast;
      logic [3:0] exp;
      string      name;
   } vec_t;

   logic clk;
   logic reset;
   logic game_en;
   logic down_fast;
   logic can_move_down;
   logic spawn_ok;
   logic move_down;
   logic lock_piece;
   logic reset_piece;
   logic game_over;

   int checks;
   int failures;
   vec_t tbl[$];

   piece_drop_ctrl #(
      .GRAV_DIV(8),
      .FAST_DIV(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .game_en      (game_en),
      .down_fast    (down_fast),
      .can_move_down(can_move_down),
      .spawn_ok     (spawn_ok),
      .move_down    (move_down),
      .lock_piece   (lock_piece),
      .reset_piece  (reset_piece),
      .game_over    (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(int n, logic en, logic sok, logic cmd, logic fast,
                                  logic [3:0] exp, string name);
      vec_t v;
      v.n = n; v.en = en; v.sok = sok; v.cmd = cmd; v.fast = fast;
      v.exp = exp; v.name = name;
      return v;
   endfunction

   task automatic applyStimulus(input logic en, input logic sok, input logic cmd,
                                input logic fast);
      game_en       = en;
      spawn_ok      = sok;
      can_move_down = cmd;
      down_fast     = fast;
   endtask

   // Expected vector packs {move_down, lock_piece, reset_piece, game_over}.
   task automatic checkOutput(input logic [3:0] exp, input string name);
      logic [3:0] got;
      got = {move_down, lock_piece, reset_piece, game_over};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got md/lk/rp/go=%b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic runCycles(input int n, input logic [3:0] exp, input string name);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         checkOutput(exp, name);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

      tbl.push_back(mkVec(1, 1, 1, 1, 0, 4'b0010, "spawn"));
      tbl.push_back(mkVec(1, 1, 1, 1, 0, 4'b0000, "check"));
      tbl.push_back(mkVec(8, 1, 1, 1, 0, 4'b0000, "fall_wait1"));
      tbl.push_back(mkVec(1, 1, 1, 1, 0, 4'b1000, "grav_step1"));
      tbl.push_back(mkVec(7, 1, 1, 1, 0, 4'b0000, "grav_wait2"));
      tbl.push_back(mkVec(1, 1, 1, 1, 0, 4'b1000, "grav_step2"));
      tbl.push_back(mkVec(5, 1, 1, 1, 0, 4'b0000, "pre_fast"));
      tbl.push_back(mkVec(1, 1, 1, 1, 1, 4'b1000, "fast_step1"));
      tbl.push_back(mkVec(1, 1, 1, 1, 1, 4'b0000, "fast_gap1"));
      tbl.push_back(mkVec(1, 1, 1, 1, 1, 4'b1000, "fast_step2"));
      tbl.push_back(mkVec(1, 1, 1, 1, 1, 4'b0000, "fast_gap2"));
      tbl.push_back(mkVec(1, 1, 1, 1, 1, 4'b1000, "fast_step3"));
      tbl.push_back(mkVec(7, 1, 1, 1, 0, 4'b0000, "slow_wait"));
      tbl.push_back(mkVec(1, 1, 1, 1, 0, 4'b1000, "slow_step"));

      #2;
      checkOutput(4'b0000, "reset_state");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      runCycles(1, 4'b0000, "idle_hold");

      foreach (tbl[k]) begin
         applyStimulus(tbl[k].en, tbl[k].sok, tbl[k].cmd, tbl[k].fast);
         runCycles(tbl[k].n, tbl[k].exp, tbl[k].name);
      end

      // Landing from a fresh period (cnt=0 after slow_step).
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      runCycles(7, 4'b0000, "land_wait");
`ifdef LOCK_DELAY_EN
      runCycles(1, 4'b0000, "grace_set");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      runCycles(7, 4'b0000, "grace_wait");
      runCycles(1, 4'b1000, "grace_slide");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      runCycles(8, 4'b0000, "grace_again");
      runCycles(7, 4'b0000, "grace_wait2");
`endif
      runCycles(1, 4'b0100, "lock");
      runCycles(1, 4'b0010, "land_respawn");
      runCycles(1, 4'b0000, "land_check");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      runCycles(8, 4'b0000, "refall_wait");
      runCycles(1, 4'b1000, "refall_step");

      // Game over: spawn collides, state holds until game_en drops.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      runCycles(1, 4'b0000, "disable");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      runCycles(1, 4'b0010, "go_spawn");
      runCycles(1, 4'b0000, "go_check");
      runCycles(51, 4'b0001, "over_hold");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      runCycles(1, 4'b0000, "over_exit");
      runCycles(2, 4'b0000, "idle_after_over");

      // Asynchronous reset while lock_piece is high.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      runCycles(1, 4'b0010, "pre_reset_spawn");
      runCycles(1, 4'b0000, "pre_reset_check");
      runCycles(8, 4'b0000, "pre_reset_fall");
`ifdef LOCK_DELAY_EN
      runCycles(8, 4'b0000, "pre_reset_grace");
`endif
      runCycles(1, 4'b0100, "lock_pre_reset");
      #2;
      reset = 1'b0;
      #1;
      checkOutput(4'b0000, "async_reset");
      #1;
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      runCycles(1, 4'b0010, "post_reset_spawn");
      runCycles(1, 4'b0000, "post_reset_check");
      runCycles(8, 4'b0000, "post_reset_fall");
      runCycles(1, 4'b1000, "post_reset_step");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
